// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
//   apb_state_e    : bridge FSM state encoding
//   APB_ERR_RDATA  : read-data pattern returned for writes, slave errors and timeouts
//   apb_cnt_width  : ACCESS timeout counter width for a given cycle limit
package apb_pkg;

  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e;

  // All-zero fill; users zero-extend it to their data width.
  localparam logic APB_ERR_RDATA = '0;

  // $clog2(cycles+1) bits, never narrower than one bit.
  function automatic int unsigned apb_cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase timeout counter for the APB master bridge.
//   clk_i     in  clock
//   rst_i     in  synchronous reset, active-high
//   clear_i   in  restart the count at zero
//   enable_i  in  count one ACCESS cycle without pready
//   expired_o out count has reached TIMEOUT_CYCLES-1 (never set when TIMEOUT_CYCLES=0)
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = apb_cnt_width(TIMEOUT_CYCLES);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired_o = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
      localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

      logic [CW-1:0] r_cnt;

      // Saturates at TIMEOUT_CYCLES so a long stall can never wrap back into range.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_cnt <= '0;
        end else if (clear_i) begin
          r_cnt <= '0;
        end else if (enable_i && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign expired_o = (r_cnt == CNT_LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: turns a core req/gnt/r_valid channel into single APB transfers.
// One transfer outstanding; optional ACCESS timeout reports stuck slaves as errors.
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_i/gnt_o                  core request / combinational accept
//   addr_i, we_i, wdata_i        request payload, held until gnt_o
//   r_valid_o, r_rdata_o, r_err_o one-cycle response strobe with data and error
//   paddr_o .. penable_o         registered APB master outputs
//   prdata_i, pready_i, pslverr_i APB slave response
//
// state      | meaning
// APB_IDLE   | no transfer; request may be granted
// APB_SETUP  | psel=1, penable=0 for exactly one cycle
// APB_ACCESS | psel=1, penable=1 until pready or timeout
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      r_valid_o,
  output logic [APB_DATA_WIDTH-1:0] r_rdata_o,
  output logic                      r_err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam logic [APB_DATA_WIDTH-1:0] ERR_RDATA = APB_DATA_WIDTH'(APB_ERR_RDATA);

  apb_state_e                r_state;
  apb_state_e                w_state_nxt;
  logic                      r_psel;
  logic                      r_penable;
  logic                      r_pwrite;
  logic                      r_rvalid;
  logic                      r_rerr;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic [APB_DATA_WIDTH-1:0] r_rdata;

  logic w_gnt;
  logic w_done;
  logic w_abort;
  logic w_expired;
  logic w_psel_nxt;
  logic w_penable_nxt;
  logic w_tmo_clr;
  logic w_tmo_en;

  assign w_gnt  = req_i && (r_state == APB_IDLE);
  assign w_done = (r_state == APB_ACCESS) && pready_i;
  // A pready arriving on the expiry cycle completes normally, so abort needs !pready.
  assign w_abort = (r_state == APB_ACCESS) && !pready_i && w_expired;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (w_tmo_clr),
    .enable_i (w_tmo_en),
    .expired_o(w_expired)
  );

  // State register plus the registered APB/response datapath.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= APB_IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_rvalid  <= 1'b0;
      r_rerr    <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_rvalid  <= w_done || w_abort;
      if (w_gnt) begin
        r_paddr  <= addr_i;
        r_pwrite <= we_i;
        r_pwdata <= wdata_i;
      end
      if (w_done) begin
        r_rerr  <= pslverr_i;
        r_rdata <= (r_pwrite || pslverr_i) ? ERR_RDATA : prdata_i;
      end else if (w_abort) begin
        r_rerr  <= 1'b1;
        r_rdata <= ERR_RDATA;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      APB_IDLE:   if (w_gnt) w_state_nxt = APB_SETUP;
      APB_SETUP:  w_state_nxt = APB_ACCESS;
      APB_ACCESS: if (w_done || w_abort) w_state_nxt = APB_IDLE;
      default:    w_state_nxt = APB_IDLE;
    endcase
  end

  // APB strobes are registered from the next state so they line up with it.
  always_comb begin
    w_psel_nxt    = (w_state_nxt != APB_IDLE);
    w_penable_nxt = (w_state_nxt == APB_ACCESS);
    w_tmo_clr     = (r_state == APB_SETUP);
    w_tmo_en      = (r_state == APB_ACCESS) && !pready_i;
  end

  assign gnt_o     = w_gnt;
  assign psel_o    = r_psel;
  assign penable_o = r_penable;
  assign pwrite_o  = r_pwrite;
  assign paddr_o   = r_paddr;
  assign pwdata_o  = r_pwdata;
  assign r_valid_o = r_rvalid;
  assign r_err_o   = r_rerr;
  assign r_rdata_o = r_rdata;

endmodule
